fake_jpeg_stim_capture: RTL

//  Self-checking harness stage wrapped around a generated combinational fake netlist.

---
 rtl/fake_netlist_pkg.sv | 27 ++
 rtl/fake_jpeg_stim_capture_misr16.sv | 26 ++
 rtl/fake_jpeg_stim_capture.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fake_netlist_pkg.sv
// Shared types, tap constants and LFSR helper
// for the fake netlist stimulus/capture harness.
`timescale 1ns/1ps
package fake_netlist_pkg;

  localparam int LFSR_W = 14;
  localparam int MISR_W = 16;

  // x^14+x^13+x^12+x^2+1 : feedback from bits 13,12,11,1
  localparam logic [13:0] LFSR14_TAPS = 14'h3802;
  // feedback from bits 15,14,12,3
  localparam logic [15:0] MISR16_TAPS = 16'hD008;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } stim_state_e;

  function automatic logic [13:0] lfsr_step(
    input logic [13:0] v
  );
    return {v[12:0], ^(v & LFSR14_TAPS)};
  endfunction

endpackage

// File: rtl/fake_jpeg_stim_capture_misr16.sv
// 16-bit serial-input signature register:
// folds one response bit per enabled cycle.
`timescale 1ns/1ps
module misr16
  import fake_netlist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);

  // shift in feedback xor response; clear wins over fold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[14:0], (^(sig & MISR16_TAPS)) ^ din};
    end
  end

endmodule

// File: rtl/fake_jpeg_stim_capture.sv
// LFSR stimulus driver and MISR response capture
// wrapped around a combinational fake netlist.
`timescale 1ns/1ps
module fake_jpeg_stim_capture
  import fake_netlist_pkg::*;
#(
  parameter int               VEC_W    = LFSR_W,
  parameter logic [VEC_W-1:0] SEED     = 14'h0001,
  parameter int               CNT_W    = 16,
  parameter int               RESP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vec_i,
  output logic [VEC_W-1:0] vec_o,
  output logic             vec_vld_o,
  input  logic             resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      sig_o
);

  localparam logic [CNT_W-1:0] DRAIN_LAST =
    (RESP_LAT > 0) ? CNT_W'(RESP_LAT - 1) : '0;

  stim_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dcnt;
  logic             clr;
  logic             cap_vld;

  // signature restarts whenever a start is accepted
  always_comb begin
    clr = (state == IDLE) && start_i;
  end

  generate
    if (RESP_LAT == 0) begin : g_nolat
      assign cap_vld = vec_vld_o;
    end else begin : g_pipe
      logic [RESP_LAT-1:0] pipe;

      // align vector valid with the netlist's response latency
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe <= '0;
        end else begin
          pipe[0] <= vec_vld_o;
          for (int i = 1; i < RESP_LAT; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign cap_vld = pipe[RESP_LAT-1];
    end
  endgenerate

  misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (cap_vld),
    .din   (resp_i),
    .sig   (sig_o)
  );

  // run control: one vector per RUN cycle, drain, single done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      vec_o     <= '0;
      vec_vld_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (num_vec_i != '0) begin
              cnt       <= num_vec_i;
              vec_o     <= SEED;
              vec_vld_o <= 1'b1;
              busy_o    <= 1'b1;
              state     <= RUN;
            end else begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            vec_vld_o <= 1'b0;
            dcnt      <= '0;
            if (RESP_LAT == 0) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              state <= DRAIN;
            end
          end else begin
            vec_o <= lfsr_step(vec_o);
          end
        end
        DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
